iic_slave_regif: RTL

// - I2C responder (target) for the OV5640/9134 control path: bit-banged SCL/SDA in, register-file bus out.
// - Oversamples SCL/SDA on clk; decodes START/STOP/repeated-START, 7-bit address, 1-2 byte register address, burst data.
// - Lets the FPGA expose a camera-style register map (16-bit reg addr default) to an external I2C master or to iic_master loopback.

---
 rtl/iic_slave_regif_if.sv | 29 ++
 rtl/iic_slave_regif.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_regif_if.sv
// Register-file side of the I2C target: address, write/read strobes,
// read data return, busy flag and an FSM state tap for checkers.
//
// Handshake: reg_wr_en and reg_rd_en are single-cycle strobes with no
// back-pressure. reg_wr_data and reg_addr are valid in the cycle reg_wr_en
// is high. For reads, reg_addr is valid while reg_rd_en is high, and the
// responder must present reg_rd_data in the cycle after reg_rd_en. The
// target samples it at the end of that cycle.
interface iic_slave_regif_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] reg_addr;
  logic              reg_wr_en;
  logic [7:0]        reg_wr_data;
  logic              reg_rd_en;
  logic [7:0]        reg_rd_data;
  logic              busy;
  logic [3:0]        dbg_state;

  modport slave (
    output reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy, dbg_state,
    input  reg_rd_data
  );

  modport master (
    input  reg_addr, reg_wr_en, reg_wr_data, reg_rd_en, busy, dbg_state,
    output reg_rd_data
  );
endinterface

// File: rtl/iic_slave_regif.sv
// I2C target that maps an external I2C master onto a simple register bus.
// SCL/SDA are oversampled on clk. The design decodes START, STOP and
// repeated START, the 7-bit device address, a 1- or 2-byte register address
// and burst data.
// Optional feature macro: IIC_SLAVE_GLITCH_FILTER_EN. When it is defined,
// SCL and SDA go through a stable-count filter after the synchronisers.
module iic_slave_regif #(
  parameter int         CLK_FRE          = 50,
  parameter logic [6:0] SLAVE_ADDR       = 7'h3C,
  parameter int         IIC_SLAVE_REG_EX = 1,
  parameter int         SDA_HOLD_NS      = 300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iic_scl,
  inout  wire              iic_sda,
  iic_slave_regif_if.slave bus
);

  localparam int ADDR_W    = 8 + 8 * IIC_SLAVE_REG_EX;
  localparam int HOLD_RAW  = SDA_HOLD_NS * CLK_FRE / 1000;
  // The hold must cover the 1-clk read-data latency, so it never drops below 2.
  localparam int HOLD_CLKS = (HOLD_RAW < 2) ? 2 : HOLD_RAW;
  localparam int HOLD_W    = $clog2(HOLD_CLKS + 1);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_DEV_ADDR   = 4'd1,
    S_DEV_ACK    = 4'd2,
    S_REG_HI     = 4'd3,
    S_REG_HI_ACK = 4'd4,
    S_REG_LO     = 4'd5,
    S_REG_LO_ACK = 4'd6,
    S_WDATA      = 4'd7,
    S_WDATA_ACK  = 4'd8,
    S_RDATA      = 4'd9,
    S_RDATA_ACK  = 4'd10,
    S_WAIT_STOP  = 4'd11
  } state_t;

  logic [1:0]        r_scl_sync;
  logic [1:0]        r_sda_sync;
  logic              w_scl;
  logic              w_sda;
  logic              r_scl_d;
  logic              r_sda_d;
  logic              w_scl_rise;
  logic              w_scl_fall;
  logic              w_start;
  logic              w_stop;
  logic [7:0]        w_byte;
  logic              w_last_bit;
  logic              w_drive;

  state_t            r_state;
  logic [2:0]        r_bit_cnt;
  logic [6:0]        r_shift;
  logic              r_rw;
  logic              r_ack_clk;
  logic [ADDR_W-1:0] r_reg_addr;
  logic              r_inc_pend;
  logic              r_wr_en;
  logic [7:0]        r_wr_data;
  logic              r_rd_en;
  logic              r_rd_lat;
  logic [7:0]        r_tx;
  logic              r_busy;
  logic              r_sda_oe;
  logic              r_hold_act;
  logic [HOLD_W-1:0] r_hold_cnt;

  // Two-flop synchronisers. They reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], iic_scl};
      r_sda_sync <= {r_sda_sync[0], iic_sda};
    end
  end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  localparam int FILT_N = (CLK_FRE / 20 < 1) ? 1 : CLK_FRE / 20;
  localparam int FILT_W = $clog2(FILT_N + 1);

  logic              r_scl_filt;
  logic              r_sda_filt;
  logic [FILT_W-1:0] r_scl_cnt;
  logic [FILT_W-1:0] r_sda_cnt;

  // Accept a level change only after FILT_N consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
      r_scl_cnt  <= '0;
      r_sda_cnt  <= '0;
    end else begin
      if (r_scl_sync[1] == r_scl_filt) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == FILT_W'(FILT_N - 1)) begin
        r_scl_filt <= r_scl_sync[1];
        r_scl_cnt  <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + FILT_W'(1);
      end
      if (r_sda_sync[1] == r_sda_filt) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == FILT_W'(FILT_N - 1)) begin
        r_sda_filt <= r_sda_sync[1];
        r_sda_cnt  <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + FILT_W'(1);
      end
    end
  end

  assign w_scl = r_scl_filt;
  assign w_sda = r_sda_filt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  // Previous-sample copies used for edge and bus-condition detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // START and STOP need SCL high on both samples. An SDA edge with SCL low
  // is therefore always treated as data.
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte     = {r_shift, w_sda};
  assign w_last_bit = (r_bit_cnt == 3'd7);

  // SDA level that the current state wants once the hold time has elapsed.
  always_comb begin
    w_drive = 1'b0;
    case (r_state)
      S_DEV_ACK, S_REG_HI_ACK, S_REG_LO_ACK, S_WDATA_ACK: w_drive = 1'b1;
      S_RDATA: w_drive = ~r_tx[7];
      default: w_drive = 1'b0;
    endcase
  end

  // Protocol FSM, SDA hold timer and register-bus strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_ack_clk  <= 1'b0;
      r_reg_addr <= '0;
      r_inc_pend <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_rd_en    <= 1'b0;
      r_rd_lat   <= 1'b0;
      r_tx       <= '0;
      r_busy     <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_hold_act <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_wr_en    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_lat   <= r_rd_en;
      r_inc_pend <= 1'b0;
      if (r_rd_lat) begin
        r_tx <= bus.reg_rd_data;
      end
      // The write address advances in the cycle after the strobe.
      if (r_inc_pend) begin
        r_reg_addr <= r_reg_addr + ADDR_W'(1);
      end
      if (r_hold_act) begin
        if (r_hold_cnt == '0) begin
          r_sda_oe   <= w_drive;
          r_hold_act <= 1'b0;
        end else begin
          r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
        end
      end

      if (w_stop) begin
        r_state    <= S_IDLE;
        r_busy     <= 1'b0;
        r_sda_oe   <= 1'b0;
        r_hold_act <= 1'b0;
        r_bit_cnt  <= '0;
      end else if (w_start) begin
        // A repeated START keeps reg_addr, so write-address-then-read works.
        r_state    <= S_DEV_ADDR;
        r_sda_oe   <= 1'b0;
        r_hold_act <= 1'b0;
        r_bit_cnt  <= '0;
      end else begin
        if (w_scl_fall && (r_state != S_IDLE)) begin
          r_hold_act <= 1'b1;
          r_hold_cnt <= HOLD_W'(HOLD_CLKS - 1);
        end
        case (r_state)
          S_DEV_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_ack_clk <= 1'b0;
                if (w_byte[7:1] == SLAVE_ADDR) begin
                  r_rw    <= w_byte[0];
                  r_busy  <= 1'b1;
                  r_state <= S_DEV_ACK;
                end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                end
              end
            end
          end
          S_REG_HI, S_REG_LO, S_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_ack_clk <= 1'b0;
                if (r_state == S_WDATA) begin
                  r_wr_en    <= 1'b1;
                  r_wr_data  <= w_byte;
                  r_inc_pend <= 1'b1;
                  r_state    <= S_WDATA_ACK;
                end else begin
                  // Address bytes arrive MSB first and shift in from the bottom.
                  r_reg_addr <= ADDR_W'({r_reg_addr, w_byte});
                  r_state    <= (r_state == S_REG_HI) ? S_REG_HI_ACK : S_REG_LO_ACK;
                end
              end
            end
          end
          S_DEV_ACK, S_REG_HI_ACK, S_REG_LO_ACK, S_WDATA_ACK: begin
            // The first SCL fall in an ACK state starts the ACK drive.
            // The fall after the 9th rise ends the ACK.
            if (w_scl_rise) begin
              r_ack_clk <= 1'b1;
            end else if (w_scl_fall && r_ack_clk) begin
              r_bit_cnt <= '0;
              case (r_state)
                S_DEV_ACK: begin
                  if (r_rw) begin
                    r_rd_en <= 1'b1;
                    r_state <= S_RDATA;
                  end else begin
                    r_state <= (IIC_SLAVE_REG_EX != 0) ? S_REG_HI : S_REG_LO;
                  end
                end
                S_REG_HI_ACK: r_state <= S_REG_LO;
                default:      r_state <= S_WDATA;
              endcase
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_ack_clk <= 1'b0;
                r_state   <= S_RDATA_ACK;
              end
            end else if (w_scl_fall) begin
              r_tx <= {r_tx[6:0], 1'b0};
            end
          end
          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_ack_clk  <= 1'b1;
                r_reg_addr <= r_reg_addr + ADDR_W'(1);
              end else begin
                r_state <= S_WAIT_STOP;
              end
            end else if (w_scl_fall && r_ack_clk) begin
              r_bit_cnt <= '0;
              r_rd_en   <= 1'b1;
              r_state   <= S_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign iic_sda         = r_sda_oe ? 1'b0 : 1'bz;
  assign bus.reg_addr    = r_reg_addr;
  assign bus.reg_wr_en   = r_wr_en;
  assign bus.reg_wr_data = r_wr_data;
  assign bus.reg_rd_en   = r_rd_en;
  assign bus.busy        = r_busy;
  assign bus.dbg_state   = r_state;

endmodule
